// File: rtl/input_conditioner_pkg.sv
// Shared types and default constants for the push-button / sensor input conditioner.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } cond_state_t;

  localparam int DEFAULT_NUM_CHANNELS      = 5;
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 33;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 32768;

endpackage

// File: rtl/input_conditioner_if.sv
// Raw pin inputs and conditioned per-channel outputs of the input conditioner.
interface input_conditioner_if
  import input_conditioner_pkg::*;
#(
  parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS
);

  logic [NUM_CHANNELS-1:0] nIn;
  logic [NUM_CHANNELS-1:0] Level;
  logic [NUM_CHANNELS-1:0] Press;
  logic [NUM_CHANNELS-1:0] Release;
  logic [NUM_CHANNELS-1:0] LongPress;

  modport master (
    output nIn,
    input  Level,
    input  Press,
    input  Release,
    input  LongPress
  );

  modport slave (
    input  nIn,
    output Level,
    output Press,
    output Release,
    output LongPress
  );

endinterface

// File: rtl/conditioner_channel.sv
// One input channel: two-flop synchroniser, optional debounce, and hold-time FSM
// producing registered Level plus Press / Release / LongPress pulses.
module conditioner_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit BYPASS            = 1'b0
) (
  input  logic Clock,
  input  logic nReset,
  input  logic n_in,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic              sync1_reg, sync2_reg;
  logic              active;
  logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  cond_state_t       state_reg, state_next;
  logic              level_reg, level_next;
  logic              press_reg, press_next;
  logic              release_reg, release_next;
  logic              long_reg, long_next;

  assign active = ~sync2_reg;

  // Synchroniser resets to the released (pulled-up) pin level.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= n_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Debounce: the level flips on the cycle the disagreement count would hit the window.
  always_comb begin
    deb_cnt_next = '0;
    level_next   = level_reg;
    if (BYPASS) begin
      level_next = active;
    end else if (active != level_reg) begin
      if (deb_cnt_reg == DEB_LAST) begin
        level_next = active;
      end else begin
        deb_cnt_next = deb_cnt_reg + DEB_W'(1);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    press_next    = 1'b0;
    release_next  = 1'b0;
    long_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (level_next) begin
          state_next    = PRESSED;
          press_next    = 1'b1;
          hold_cnt_next = '0;
        end
      end
      PRESSED: begin
        if (!level_next) begin
          state_next    = IDLE;
          release_next  = 1'b1;
          hold_cnt_next = '0;
        end else begin
          if (hold_cnt_reg != HOLD_MAX) begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
          if (hold_cnt_reg == HOLD_LAST) begin
            state_next = LONG;
            long_next  = 1'b1;
          end
        end
      end
      LONG: begin
        // Counter stays saturated here, so LongPress cannot repeat until re-press.
        if (!level_next) begin
          state_next    = IDLE;
          release_next  = 1'b1;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      deb_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      state_reg    <= IDLE;
      level_reg    <= 1'b0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
      long_reg     <= 1'b0;
    end else begin
      deb_cnt_reg  <= deb_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      state_reg    <= state_next;
      level_reg    <= level_next;
      press_reg    <= press_next;
      release_reg  <= release_next;
      long_reg     <= long_next;
    end
  end

  assign level         = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign long_pulse    = long_reg;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: one independent conditioner_channel per active-low pin.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int                      NUM_CHANNELS      = DEFAULT_NUM_CHANNELS,
  parameter int                      DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int                      LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter logic [NUM_CHANNELS-1:0] DEBOUNCE_MASK     = '1
) (
  input  logic                Clock,
  input  logic                nReset,
  input_conditioner_if.slave  bus
);

  logic [NUM_CHANNELS-1:0] level_vec;
  logic [NUM_CHANNELS-1:0] press_vec;
  logic [NUM_CHANNELS-1:0] release_vec;
  logic [NUM_CHANNELS-1:0] long_vec;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    // A cleared mask bit marks a clean sensor input that skips debouncing.
    conditioner_channel #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .BYPASS            (!DEBOUNCE_MASK[gi])
    ) u_channel (
      .Clock         (Clock),
      .nReset        (nReset),
      .n_in          (bus.nIn[gi]),
      .level         (level_vec[gi]),
      .press_pulse   (press_vec[gi]),
      .release_pulse (release_vec[gi]),
      .long_pulse    (long_vec[gi])
    );
  end

  assign bus.Level     = level_vec;
  assign bus.Press     = press_vec;
  assign bus.Release   = release_vec;
  assign bus.LongPress = long_vec;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter NUM_CHANNELS, default 5, number of independent active-low inputs (Mode, Trip, Button3, Fork, Crank order).
REQ-002 Parameter DEBOUNCE_CYCLES, default 33 (about 1 ms at 32.768 kHz), stability window in clocks; legal range 1..1023.
REQ-003 Parameter LONG_PRESS_CYCLES, default 32768 (1 s), hold time to LongPress in clocks; must be greater than DEBOUNCE_CYCLES.
REQ-004 Parameter DEBOUNCE_MASK, NUM_CHANNELS bits, default all ones; a 0 bit bypasses debounce for that channel (sensor use).
REQ-005 Clock  input  1  system clock; single clock domain.
REQ-006 nReset  input  1  asynchronous, active-low reset.
REQ-007 nIn  input  NUM_CHANNELS  raw pins, low = active, asynchronous to Clock, externally pulled up.
REQ-008 Level  output  NUM_CHANNELS  debounced state, 1 = active.
REQ-009 Press  output  NUM_CHANNELS  one-cycle pulse on Level 0->1.
REQ-010 Release  output  NUM_CHANNELS  one-cycle pulse on Level 1->0.
REQ-011 LongPress  output  NUM_CHANNELS  one-cycle pulse when held LONG_PRESS_CYCLES after Press.

Function
REQ-012 Each nIn bit shall pass through a two-flop synchroniser, reset value 1 (inactive), before any other logic.
REQ-013 Debounced channel: counter increments each cycle that synchronised value differs from Level; clears to 0 in any cycle they agree.
REQ-014 Debounced channel: Level shall toggle on the edge where the counter would reach DEBOUNCE_CYCLES; counter clears on that same edge.
REQ-015 Latency: nIn stable from edge E0 gives Level/Press/Release valid after edge E0+1+DEBOUNCE_CYCLES (bypassed: E0+2).
REQ-016 Glitch shorter than DEBOUNCE_CYCLES consecutive cycles shall produce no Level change and no pulse.
REQ-017 Bypassed channel (DEBOUNCE_MASK bit 0): Level equals synchroniser output delayed one register.
REQ-018 Press and Release high for exactly one cycle per Level transition; never both high on one channel.
REQ-019 Hold counter: cleared at Press, increments each cycle Level=1, saturates at LONG_PRESS_CYCLES; width $clog2(LONG_PRESS_CYCLES+1).
REQ-020 LongPress pulses once when hold counter reaches LONG_PRESS_CYCLES; no repeat until Level has returned to 0 and a new Press occurs.
REQ-021 Release before LONG_PRESS_CYCLES shall produce no LongPress; hold counter clears on Release.
REQ-022 Channels fully independent; simultaneous activity on any subset shall produce the same per-channel outputs as activity in isolation.
REQ-023 Per-channel state machine: IDLE (Level 0) -> PRESSED on debounced assertion -> LONG on reaching LONG_PRESS_CYCLES -> IDLE on debounced release, from PRESSED or LONG.

Reset
REQ-024 Asserting nReset shall asynchronously set synchronisers to 1, clear all counters, force IDLE, and drive Level, Press, Release, LongPress to 0.
REQ-025 Reset mid-press shall emit no Release; an input still active after reset deassertion shall produce a fresh Press after normal latency.
REQ-026 All outputs are registered; no output is combinationally dependent on nIn.

Structure
REQ-027 Package input_conditioner_pkg holds the state enum (IDLE, PRESSED, LONG) and default constants for channel count, debounce, and long-press cycles.
REQ-028 Sub-module conditioner_channel implements one channel (sync, debounce, hold FSM) and is instantiated NUM_CHANNELS times via generate.

Verification (bench: NUM_CHANNELS=5, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, DEBOUNCE_MASK=5'b00111)
REQ-029 nIn[0] low, held at edge E0 -> Level[0]=1 and Press[0] one cycle after edge E0+5; Release[0] after same latency once nIn[0] returns high.
REQ-030 nIn[1] low for 3 cycles, then high -> Level[1] stays 0; no Press/Release.
REQ-031 nIn[2] held low 30 cycles -> exactly one LongPress[2], 16 cycles after Press[2]; low for 10 cycles -> no LongPress.
REQ-032 nIn[3] (bypassed) 1-cycle-wide low pulse aligned to setup -> Level[3] high for exactly one cycle, Press[3] and Release[3] once each.
REQ-033 All five channels asserted on the same edge -> Press pulses match per-channel latency (bypassed channels earlier), with no cross-channel interference.
REQ-034 nReset asserted while channel 0 is in LONG -> outputs 0 immediately; nIn[0] kept low -> new Press[0] five cycles after reset release.
